// File: rtl/pzbcm_packet_arbiter.sv
// -----------------------------------------------------------------------------
// pzbcm_packet_arbiter
//
// Merges REQUESTS valid/ready packet sources onto one output channel using
// round-robin arbitration. A grant is locked from arbitration until the granted
// requester's last beat is accepted at the input side, so packets never
// interleave. With REGISTERED_OUTPUT=1 accepted beats go through a 2-entry FIFO
// that keeps full throughput; with REGISTERED_OUTPUT=0 the locked requester is
// passed straight through.
//
// Ports:
//   i_clk, i_rst_n     clock, asynchronous active-low reset
//   i_valid/o_ready    per-requester beat handshake
//   i_data, i_last     per-requester payload and last-beat flag
//   o_valid/i_ready    merged output handshake
//   o_data, o_last     merged payload and last-beat flag
//   o_grant            one-hot locked requester, zero when idle
//   o_busy             high while a grant is locked
// -----------------------------------------------------------------------------
module pzbcm_packet_arbiter #(
   parameter int REQUESTS          = 4,
   parameter int DATA_WIDTH        = 32,
   parameter int REGISTERED_OUTPUT = 1
) (
   input  logic                                 i_clk,
   input  logic                                 i_rst_n,
   input  logic [REQUESTS-1:0]                  i_valid,
   output logic [REQUESTS-1:0]                  o_ready,
   input  logic [REQUESTS-1:0][DATA_WIDTH-1:0]  i_data,
   input  logic [REQUESTS-1:0]                  i_last,
   output logic                                 o_valid,
   input  logic                                 i_ready,
   output logic [DATA_WIDTH-1:0]                o_data,
   output logic                                 o_last,
   output logic [REQUESTS-1:0]                  o_grant,
   output logic                                 o_busy
);

   localparam int PTR_W = (REQUESTS > 1) ? $clog2(REQUESTS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [PTR_W-1:0]   grant_q, grant_d;

   logic [PTR_W-1:0]   sel_s;
   logic [PTR_W-1:0]   next_ptr_s;
   logic               any_valid_s;
   logic               locked_s;
   logic               ready_s;
   logic               accept_s;
   logic [REQUESTS-1:0] grant_onehot_s;

   assign any_valid_s    = |i_valid;
   assign locked_s       = (state_q == ST_LOCKED);
   assign grant_onehot_s = {{(REQUESTS-1){1'b0}}, 1'b1} << grant_q;
   assign accept_s       = locked_s && i_valid[grant_q] && ready_s;
   assign next_ptr_s     = (grant_q == PTR_W'(REQUESTS - 1)) ? {PTR_W{1'b0}}
                                                             : grant_q + PTR_W'(1);

   assign o_ready = ready_s  ? grant_onehot_s : {REQUESTS{1'b0}};
   assign o_grant = locked_s ? grant_onehot_s : {REQUESTS{1'b0}};
   assign o_busy  = locked_s;

   // Round-robin search: first valid requester at or above ptr, wrapping to 0.
   int               cand_s;
   logic [PTR_W-1:0] cand_idx_s;
   logic             found_s;
   always_comb begin
      sel_s      = ptr_q;
      found_s    = 1'b0;
      cand_s     = 0;
      cand_idx_s = {PTR_W{1'b0}};
      for (int i = 0; i < REQUESTS; i++) begin
         cand_s = int'(ptr_q) + i;
         if (cand_s >= REQUESTS) begin
            cand_s = cand_s - REQUESTS;
         end else begin
            cand_s = cand_s;
         end
         cand_idx_s = PTR_W'(cand_s);
         if (!found_s && i_valid[cand_idx_s]) begin
            found_s = 1'b1;
            sel_s   = cand_idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Lock FSM next state: grant in IDLE, release on accepted last beat.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      case (state_q)
         ST_IDLE: begin
            if (any_valid_s) begin
               grant_d = sel_s;
               state_d = ST_LOCKED;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_LOCKED: begin
            // Packet end is taken when the last beat enters, not when it leaves.
            if (accept_s && i_last[grant_q]) begin
               state_d = ST_IDLE;
               ptr_d   = next_ptr_s;
            end else begin
               state_d = ST_LOCKED;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Lock FSM, pointer and grant registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         ptr_q   <= {PTR_W{1'b0}};
         grant_q <= {PTR_W{1'b0}};
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
      end
   end

   if (REGISTERED_OUTPUT != 0) begin : g_fifo
      logic [1:0][DATA_WIDTH:0] mem_q, mem_d;
      logic                     wr_q, wr_d;
      logic                     rd_q, rd_d;
      logic [1:0]               count_q, count_d;
      logic                     push_s;
      logic                     pop_s;

      assign ready_s = locked_s && (count_q != 2'd2);
      assign o_valid = (count_q != 2'd0);
      assign o_data  = mem_q[rd_q][DATA_WIDTH-1:0];
      assign o_last  = mem_q[rd_q][DATA_WIDTH];

      // FIFO next state; push and pop may coincide.
      always_comb begin
         push_s  = accept_s;
         pop_s   = (count_q != 2'd0) && i_ready;
         mem_d   = mem_q;
         wr_d    = wr_q;
         rd_d    = rd_q;
         count_d = count_q;
         if (push_s) begin
            mem_d[wr_q] = {i_last[grant_q], i_data[grant_q]};
            wr_d        = ~wr_q;
         end else begin
            wr_d = wr_q;
         end
         if (pop_s) begin
            rd_d = ~rd_q;
         end else begin
            rd_d = rd_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end

      // FIFO storage and pointers; reset discards any held beats.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            mem_q   <= {2{{(DATA_WIDTH+1){1'b0}}}};
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            count_q <= 2'd0;
         end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
         end
      end
   end else begin : g_pass
      assign ready_s = locked_s && i_ready;
      assign o_valid = locked_s && i_valid[grant_q];
      // Gate with the lock so idle outputs read zero.
      assign o_data  = locked_s ? i_data[grant_q] : {DATA_WIDTH{1'b0}};
      assign o_last  = locked_s && i_last[grant_q];
   end

endmodule

// File: tb/tb_pzbcm_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pzbcm_packet_arbiter
//
// Bench for pzbcm_packet_arbiter with default parameters (4 requesters,
// 32-bit data, registered output). A directed vector table, hand-written
// corner sequences and a randomized phase checked against a transaction-level
// model (locked requester index, pointer, and a queue of buffered beats).
// Payload encoding: {requester[7:0], packet number[15:0], beat index[7:0]}.
// -----------------------------------------------------------------------------
module tb_pzbcm_packet_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic                 i_clk = 1'b0;
   logic                 i_rst_n;
   logic [N-1:0]         i_valid;
   logic [N-1:0]         o_ready;
   logic [N-1:0][DW-1:0] i_data;
   logic [N-1:0]         i_last;
   logic                 o_valid;
   logic                 i_ready;
   logic [DW-1:0]        o_data;
   logic                 o_last;
   logic [N-1:0]         o_grant;
   logic                 o_busy;

   always #5 i_clk = ~i_clk;

   pzbcm_packet_arbiter #(
      .REQUESTS          (N),
      .DATA_WIDTH        (DW),
      .REGISTERED_OUTPUT (1)
   ) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_valid (i_valid),
      .o_ready (o_ready),
      .i_data  (i_data),
      .i_last  (i_last),
      .o_valid (o_valid),
      .i_ready (i_ready),
      .o_data  (o_data),
      .o_last  (o_last),
      .o_grant (o_grant),
      .o_busy  (o_busy)
   );

   typedef struct {
      logic [3:0]  vld;
      logic [3:0]  lst;
      logic [31:0] d0;
      logic [31:0] d1;
      logic        rdy;
      logic [3:0]  e_rdy;
      logic [3:0]  e_gnt;
      logic        e_busy;
      logic        e_val;
      logic [31:0] e_data;
      logic        e_last;
   } vec_t;

   vec_t vecs[10];

   int pass_cnt  = 0;
   int total_cnt = 0;

   // reference model
   int          m_lock;
   int          m_ptr;
   logic [32:0] m_q[$];

   // packet generators
   int g_beat[N];
   int g_len[N];
   int g_pkt[N];
   int fix_len[N];

   // observation logs
   int         g_log[$];
   int         g_cyc[$];
   int         o_src[$];
   int         o_beat[$];
   int         o_cyc[$];
   int         cyc;
   logic [3:0] prev_grant;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) begin
         pass_cnt++;
      end else begin
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic int oh2idx(input logic [3:0] v);
      int r;
      r = -1;
      for (int i = 0; i < N; i++) if (v[i]) r = i;
      return r;
   endfunction

   function automatic int new_len(input int r);
      return (fix_len[r] > 0) ? fix_len[r] : int'($urandom_range(1, 4));
   endfunction

   task automatic model_reset();
      m_lock = -1;
      m_ptr  = 0;
      m_q.delete();
      for (int r = 0; r < N; r++) begin
         g_beat[r] = 0;
         g_pkt[r]  = 0;
         g_len[r]  = new_len(r);
      end
      g_log.delete(); g_cyc.delete();
      o_src.delete(); o_beat.delete(); o_cyc.delete();
      prev_grant = 4'b0000;
      cyc = 0;
   endtask

   task automatic model_check();
      logic [3:0] eg;
      eg = (m_lock >= 0) ? 4'(1 << m_lock) : 4'b0000;
      chk("m_ready", {28'd0, o_ready}, {28'd0, (m_q.size() < 2) ? eg : 4'b0000});
      chk("m_grant", {28'd0, o_grant}, {28'd0, eg});
      chk("m_busy",  {31'd0, o_busy},  {31'd0, (m_lock >= 0)});
      chk("m_valid", {31'd0, o_valid}, {31'd0, (m_q.size() != 0)});
      if (m_q.size() != 0) begin
         chk("m_data", o_data, m_q[0][31:0]);
         chk("m_last", {31'd0, o_last}, {31'd0, m_q[0][32]});
      end
   endtask

   task automatic model_advance(output int acc_idx);
      int  k;
      int  j;
      bit  acc;
      bit  pop;
      k       = m_lock;
      acc_idx = -1;
      acc     = (k >= 0) && i_valid[k] && (m_q.size() < 2);
      pop     = (m_q.size() > 0) && i_ready;
      if (pop) void'(m_q.pop_front());
      if (k < 0) begin
         for (int i = 0; i < N; i++) begin
            j = (m_ptr + i) % N;
            if (m_lock < 0 && i_valid[j]) m_lock = j;
         end
      end else if (acc) begin
         m_q.push_back({i_last[k], i_data[k]});
         acc_idx = k;
         if (i_last[k]) begin
            m_ptr  = (k + 1) % N;
            m_lock = -1;
         end
      end
   endtask

   // One clock: settle, log, compare against model, advance model, clock.
   task automatic step(output int acc_idx);
      #1;
      if (o_grant != 4'b0000 && prev_grant == 4'b0000) begin
         g_log.push_back(oh2idx(o_grant));
         g_cyc.push_back(cyc);
      end
      prev_grant = o_grant;
      if (o_valid && i_ready) begin
         o_src.push_back(int'(o_data[31:24]));
         o_beat.push_back(int'(o_data[7:0]));
         o_cyc.push_back(cyc);
      end
      model_check();
      model_advance(acc_idx);
      @(posedge i_clk);
      #1;
      cyc++;
   endtask

   task automatic gen_cycle(input logic [3:0] vmask, input logic rdy);
      int a;
      for (int r = 0; r < N; r++) begin
         i_valid[r] = vmask[r];
         i_data[r]  = {8'(r), 16'(g_pkt[r]), 8'(g_beat[r])};
         i_last[r]  = (g_beat[r] == g_len[r] - 1);
      end
      i_ready = rdy;
      step(a);
      if (a >= 0) begin
         g_beat[a]++;
         if (g_beat[a] >= g_len[a]) begin
            g_beat[a] = 0;
            g_pkt[a]++;
            g_len[a] = new_len(a);
         end
      end
   endtask

   task automatic do_reset();
      i_rst_n = 1'b0;
      i_valid = 4'($urandom);
      i_last  = 4'($urandom);
      i_ready = 1'($urandom);
      for (int r = 0; r < N; r++) i_data[r] = $urandom;
      @(posedge i_clk);
      @(posedge i_clk);
      #1;
      chk("rst_valid", {31'd0, o_valid}, 32'd0);
      chk("rst_ready", {28'd0, o_ready}, 32'd0);
      chk("rst_grant", {28'd0, o_grant}, 32'd0);
      chk("rst_busy",  {31'd0, o_busy},  32'd0);
      chk("rst_data",  o_data,           32'd0);
      chk("rst_last",  {31'd0, o_last},  32'd0);
      i_valid = 4'b0000;
      i_last  = 4'b0000;
      i_ready = 1'b1;
      for (int r = 0; r < N; r++) i_data[r] = 32'd0;
      i_rst_n = 1'b1;
      model_reset();
      gen_cycle(4'b0000, 1'b1);
      gen_cycle(4'b0000, 1'b1);
      cyc = 0;
   endtask

   task automatic set_len(input int l0, input int l1, input int l2, input int l3);
      fix_len[0] = l0; fix_len[1] = l1; fix_len[2] = l2; fix_len[3] = l3;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_w[4];
      int bound;

      i_rst_n = 1'b0;
      i_valid = 4'b0000;
      i_last  = 4'b0000;
      i_ready = 1'b0;
      for (int r = 0; r < N; r++) i_data[r] = 32'd0;

      // ---------------- directed vector table ----------------
      //            vld      lst      d0      d1      rdy   e_rdy    e_gnt    busy  val   data    last
      vecs[0] = '{4'b0010, 4'b0010, 32'h0,  32'hA1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0};
      vecs[1] = '{4'b0010, 4'b0010, 32'h0,  32'hA1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0,  1'b0};
      vecs[2] = '{4'b0000, 4'b0000, 32'h0,  32'h0,  1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hA1, 1'b1};
      vecs[3] = '{4'b0011, 4'b0010, 32'hB0, 32'hC1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0};
      vecs[4] = '{4'b0011, 4'b0010, 32'hB0, 32'hC1, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0, 32'h0,  1'b0};
      vecs[5] = '{4'b0011, 4'b0011, 32'hB1, 32'hC1, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1, 32'hB0, 1'b0};
      vecs[6] = '{4'b0010, 4'b0010, 32'h0,  32'hC1, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hB1, 1'b1};
      vecs[7] = '{4'b0010, 4'b0010, 32'h0,  32'hC1, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0, 32'h0,  1'b0};
      vecs[8] = '{4'b0000, 4'b0000, 32'h0,  32'h0,  1'b1, 4'b0000, 4'b0000, 1'b0, 1'b1, 32'hC1, 1'b1};
      vecs[9] = '{4'b0000, 4'b0000, 32'h0,  32'h0,  1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0};

      set_len(1, 1, 1, 1);
      do_reset();
      for (int v = 0; v < 10; v++) begin
         i_valid   = vecs[v].vld;
         i_last    = vecs[v].lst;
         i_data[0] = vecs[v].d0;
         i_data[1] = vecs[v].d1;
         i_data[2] = 32'd0;
         i_data[3] = 32'd0;
         i_ready   = vecs[v].rdy;
         #1;
         chk($sformatf("vec%0d_ready", v), {28'd0, o_ready}, {28'd0, vecs[v].e_rdy});
         chk($sformatf("vec%0d_grant", v), {28'd0, o_grant}, {28'd0, vecs[v].e_gnt});
         chk($sformatf("vec%0d_busy", v),  {31'd0, o_busy},  {31'd0, vecs[v].e_busy});
         chk($sformatf("vec%0d_valid", v), {31'd0, o_valid}, {31'd0, vecs[v].e_val});
         if (vecs[v].e_val) begin
            chk($sformatf("vec%0d_data", v), o_data, vecs[v].e_data);
            chk($sformatf("vec%0d_last", v), {31'd0, o_last}, {31'd0, vecs[v].e_last});
         end
         @(posedge i_clk);
         #1;
      end

      // ---------------- fair rotation ----------------
      set_len(2, 2, 2, 2);
      do_reset();
      for (int c = 0; c < 16; c++) gen_cycle(4'b1111, 1'b1);
      chk("rot_grants", g_log.size() >= 5, 1);
      for (int i = 0; i < 5 && i < g_log.size(); i++) begin
         chk($sformatf("rot_grant%0d", i), g_log[i], i % 4);
         if (i > 0) chk($sformatf("rot_period%0d", i), g_cyc[i] - g_cyc[i-1], 3);
      end
      chk("rot_beats", o_beat.size() >= 8, 1);
      for (int i = 0; i < 8 && i < o_beat.size(); i++)
         chk($sformatf("rot_beat%0d", i), o_beat[i], i % 2);

      // ---------------- no interleaving (held lock) ----------------
      set_len(4, 2, 1, 1);
      do_reset();
      for (int c = 0; c < 3; c++)  gen_cycle(4'b0011, 1'b1);
      for (int c = 0; c < 3; c++)  gen_cycle(4'b0010, 1'b1);
      for (int c = 0; c < 11; c++) gen_cycle(4'b0011, 1'b1);
      for (int c = 0; c < 3; c++)  gen_cycle(4'b0000, 1'b1);
      exp_w = '{0, 0, 0, 0};
      chk("nil_outs", o_src.size() >= 6, 1);
      for (int i = 0; i < 6 && i < o_src.size(); i++)
         chk($sformatf("nil_src%0d", i), o_src[i], (i < 4) ? 0 : 1);
      chk("nil_grants", g_log.size() >= 2, 1);
      if (g_log.size() >= 2) begin
         chk("nil_g0", g_log[0], 0);
         chk("nil_g1", g_log[1], 1);
         chk("nil_gap", g_cyc[1] - g_cyc[0], 8);
      end

      // ---------------- backpressure ----------------
      set_len(6, 1, 1, 1);
      do_reset();
      for (int c = 0; c < 18; c++) begin
         if (c == 5) begin
            chk("bp_ready_low", {28'd0, o_ready}, 32'd0);
            chk("bp_valid",     {31'd0, o_valid}, 32'd1);
            chk("bp_head",      {24'd0, o_data[7:0]}, 32'd1);
         end
         gen_cycle((g_pkt[0] == 0) ? 4'b0001 : 4'b0000, (c >= 3 && c < 8) ? 1'b0 : 1'b1);
      end
      chk("bp_count", o_beat.size(), 6);
      for (int i = 0; i < 6 && i < o_beat.size(); i++) begin
         chk($sformatf("bp_beat%0d", i), o_beat[i], i);
         if (i >= 2) chk($sformatf("bp_gap%0d", i), o_cyc[i] - o_cyc[i-1], 1);
      end

      // ---------------- pointer wrap and skip ----------------
      set_len(1, 1, 1, 1);
      do_reset();
      bound = 0;
      while (g_pkt[2] < 2 && bound < 20) begin gen_cycle(4'b0100, 1'b1); bound++; end
      chk("wrap_setup", g_pkt[2], 2);
      bound = 0;
      while (!(g_pkt[0] >= 1 && g_pkt[3] >= 1) && bound < 20) begin
         gen_cycle(4'b1001, 1'b1);
         bound++;
      end
      chk("wrap_done", bound < 20, 1);
      gen_cycle(4'b0000, 1'b1);
      gen_cycle(4'b0000, 1'b1);
      exp_w = '{2, 2, 3, 0};
      chk("wrap_grants", g_log.size(), 4);
      for (int i = 0; i < 4 && i < g_log.size(); i++)
         chk($sformatf("wrap_g%0d", i), g_log[i], exp_w[i]);

      // ---------------- reset mid-packet ----------------
      set_len(1, 3, 1, 1);
      do_reset();
      bound = 0;
      while (g_pkt[2] < 1 && bound < 20) begin gen_cycle(4'b0100, 1'b1); bound++; end
      bound = 0;
      while (g_beat[1] < 1 && bound < 20) begin gen_cycle(4'b0010, 1'b0); bound++; end
      chk("mid_setup", g_beat[1], 1);
      chk("mid_fifo_nonempty", {31'd0, o_valid}, 32'd1);
      #2;
      i_rst_n = 1'b0;
      #1;
      chk("mid_valid", {31'd0, o_valid}, 32'd0);
      chk("mid_grant", {28'd0, o_grant}, 32'd0);
      chk("mid_busy",  {31'd0, o_busy},  32'd0);
      @(posedge i_clk);
      #1;
      i_rst_n = 1'b1;
      model_reset();
      gen_cycle(4'b1010, 1'b1);
      chk("mid_restart", {28'd0, o_grant}, 32'h2);
      for (int c = 0; c < 6; c++) gen_cycle(4'b1010, 1'b1);

      // ---------------- randomized against model ----------------
      set_len(0, 0, 0, 0);
      do_reset();
      for (int c = 0; c < 2000; c++)
         gen_cycle(4'($urandom), ($urandom_range(0, 3) != 0));
      for (int c = 0; c < 4; c++) gen_cycle(4'b0000, 1'b1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/pzbcm_packet_arbiter.md
# pzbcm_packet_arbiter

Shares one valid/ready output channel among `REQUESTS` packet sources with round-robin fairness. Once a requester is granted, the grant is locked until that requester's last beat is accepted, so packets are never interleaved. An optional 2-entry output buffer registers the output channel and keeps full throughput. Intended use is merging request and response streams in front of shared buses and memories.

## Interface
- `REQUESTS`, default 4: number of input channels; must be at least 2.
- `DATA_WIDTH`, default 32: payload width per beat.
- `REGISTERED_OUTPUT`, default 1:
  - 1 selects a 2-entry output FIFO.
  - 0 selects a combinational pass-through.
- `i_clk`, input, 1: clock.
- `i_rst_n`, input, 1: reset, asynchronous, active-low.
- `i_valid`, input, [REQUESTS-1:0]: per-requester beat valid.
- `o_ready`, output, [REQUESTS-1:0]: per-requester beat ready.
- `i_data`, input, [REQUESTS-1:0][DATA_WIDTH-1:0]: per-requester payload.
- `i_last`, input, [REQUESTS-1:0]: per-requester last-beat flag.
- `o_valid`, output, 1: merged beat valid.
- `i_ready`, input, 1: downstream ready.
- `o_data`, output, DATA_WIDTH: merged payload.
- `o_last`, output, 1: merged last-beat flag.
- `o_grant`, output, [REQUESTS-1:0]: one-hot locked requester; all zero when idle.
- `o_busy`, output, 1: high while a grant is locked.

## Operation
- **FSM states:** IDLE and LOCKED.
- **Round-robin pointer:** `ptr` is $clog2(REQUESTS) bits wide and resets to 0.
- **IDLE:**
  - If any `i_valid` is high, select the first requester k with `i_valid[k]` high, searching from `ptr` upward and wrapping N-1 to 0.
  - Register k as the grant and go to LOCKED next cycle.
  - No beat is accepted in IDLE; all `o_ready` bits are 0.
  - If no `i_valid` is high, stay in IDLE and leave `ptr` unchanged.
- **LOCKED (grant k):**
  - Only `o_ready[k]` can be 1; all other `o_ready` bits are 0.
  - A beat is accepted when `i_valid[k]` and `o_ready[k]` are both high.
  - When a beat with `i_last[k]` is accepted: `ptr` becomes (k+1) mod REQUESTS and the FSM returns to IDLE next cycle.
  - The packet end is taken at the input side, not when the beat leaves the output.
- **Held lock:** if the granted requester deasserts `i_valid` mid-packet, the lock is held indefinitely. There is no timeout and no re-arbitration. Other requesters wait.
- **Single-beat packets:** `i_valid` and `i_last` high on the first beat ends the lock after one accepted beat.
- **REGISTERED_OUTPUT=1:**
  - Accepted beats (data, last) are written into a 2-entry FIFO.
  - `o_ready[k]` = LOCKED && count<2.
  - `o_valid` = count!=0; `o_data`/`o_last` come from the FIFO head.
  - A pop occurs on `o_valid` && `i_ready`; push and pop may happen in the same cycle.
  - The FIFO keeps draining across IDLE, so the next arbitration overlaps the drain.
- **REGISTERED_OUTPUT=0:**
  - `o_valid` = LOCKED && `i_valid[k]`.
  - `o_data`/`o_last` = `i_data[k]`/`i_last[k]`.
  - `o_ready[k]` = LOCKED && `i_ready`.
- `o_grant` is the one-hot of k in LOCKED, 0 in IDLE.
- `o_busy` = (state==LOCKED).

## Timing
- **Reset values:** state IDLE, `ptr`=0, FIFO empty.
  - `o_valid`=0, `o_ready`=0, `o_grant`=0, `o_busy`=0.
  - `o_data`=0, `o_last`=0.
- **Async reset mid-packet:**
  - Lock, pointer and FIFO clear immediately.
  - Beats held in the FIFO are discarded.
- **Arbitration latency:** 1 cycle. Request seen in IDLE at cycle t gives `o_grant`/`o_ready` at t+1.
- **Packet overhead:** back-to-back packets cost 1 idle cycle between them, including from the same requester.
- **REGISTERED_OUTPUT=1:**
  - Input accept at cycle t gives `o_valid` at t+1.
  - Sustains 1 beat/cycle within a packet with `i_ready`=1.
  - With `i_ready`=0, at most 2 beats are absorbed, then `o_ready` drops.
- **REGISTERED_OUTPUT=0:** zero-latency combinational path from `i_valid`/`i_data` to `o_valid`/`o_data` and from `i_ready` to `o_ready`.
- **Ordering:** beat order within and across packets equals the acceptance order. No loss and no duplication under any backpressure pattern.

## Test plan
- **Reset:** assert `i_rst_n`=0 with random inputs.
  - All outputs read 0.
  - After release with all `i_valid`=0, `o_busy` stays 0.
- **Fair rotation:** REQUESTS=4, REGISTERED_OUTPUT=1, all four send 2-beat packets continuously, `i_ready`=1.
  - Grants go 0,1,2,3,0.
  - Each packet takes 3 cycles (1 arbitration + 2 beats).
  - `o_last` is high on every 2nd output beat.
- **No interleaving:** req0 sends a 4-beat packet with `i_valid` dropped for 3 cycles after beat 2; req1 is valid throughout.
  - `o_ready[1]`=0 until the cycle after req0's last is accepted.
  - Output is four req0 beats, then req1.
- **Backpressure:** `i_ready`=0 for 5 cycles during a 6-beat packet.
  - FIFO holds exactly 2 beats and `o_ready[k]` goes 0.
  - After `i_ready`=1, all 6 beats appear in order with no gaps.
- **Pointer wrap and skip:** req2 sends two single-beat packets; then req0 and req3 request simultaneously with `ptr`=3.
  - Grants go 2, 2, 3, 0.
- **Reset mid-packet:** assert reset after beat 1 of a 3-beat packet with the FIFO non-empty.
  - `o_valid`=0 and `o_grant`=0 immediately.
  - The next arbitration restarts at requester 0.
